// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_onehot_arbiter
//  Description : Round-robin arbiter with a registered one-hot grant, binary
//                grant index, bounded hold time with forced preemption and a
//                one-cycle idle gap between successive owners.
//  Revision    : 1.0  - initial release
// ============================================================================
module rr_onehot_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  done,
    output logic [NUM_REQ-1:0]  gnt,
    output logic                gnt_valid,
    output logic [ID_W-1:0]     gnt_id,
    output logic                timeout
);

    // Pointer resets to the top index so that requester 0 wins first.
    localparam logic [ID_W-1:0] c_LAST_RST  = ID_W'(NUM_REQ - 1);
    // Last hold-counter value at which the owner is still allowed to stay.
    localparam logic [7:0]      c_HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_gnt_valid;
    logic [ID_W-1:0]      r_gnt_id;
    logic [ID_W-1:0]      r_last;
    logic [7:0]           r_hold;
    logic                 r_timeout;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic                 w_gnt_valid_nxt;
    logic [ID_W-1:0]      w_gnt_id_nxt;
    logic [ID_W-1:0]      w_last_nxt;
    logic [7:0]           w_hold_nxt;
    logic                 w_timeout_nxt;

    logic                 w_pick_valid;
    logic [ID_W-1:0]      w_pick_id;
    logic [NUM_REQ-1:0]   w_pick_onehot;
    int                   w_best_dist;
    int                   w_dist;

    logic                 w_own_done;
    logic                 w_own_req;

    // Cyclic search starting just above the pointer: the requester with the
    // smallest forward distance from last+1 wins.
    always_comb begin
        w_pick_valid  = 1'b0;
        w_pick_id     = '0;
        w_pick_onehot = '0;
        w_best_dist   = NUM_REQ;
        w_dist        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist   = w_dist;
                w_pick_valid  = 1'b1;
                w_pick_id     = ID_W'(i);
                w_pick_onehot = '0;
                w_pick_onehot[i] = 1'b1;
            end
        end
    end

    // The one-hot grant masks out every non-owner's done/req bit.
    assign w_own_done = |(done & r_gnt);
    assign w_own_req  = |(req  & r_gnt);

    // Next-state and next-output decode for the IDLE/GRANT/GAP controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_id_nxt    = r_gnt_id;
        w_last_nxt      = r_last;
        w_hold_nxt      = r_hold;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_GRANT: begin
                if (w_own_done || !w_own_req) begin
                    // Normal release wins even if the hold limit is reached.
                    w_state_nxt     = S_GAP;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_last_nxt      = r_gnt_id;
                end else if (r_hold == c_HOLD_LAST) begin
                    w_state_nxt     = S_GAP;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_last_nxt      = r_gnt_id;
                    w_timeout_nxt   = 1'b1;
                end else begin
                    w_hold_nxt      = r_hold + 8'd1;
                end
            end
            default: begin
                // IDLE and the GAP exit arbitrate identically.
                if (w_pick_valid) begin
                    w_state_nxt     = S_GRANT;
                    w_gnt_nxt       = w_pick_onehot;
                    w_gnt_valid_nxt = 1'b1;
                    w_gnt_id_nxt    = w_pick_id;
                    w_hold_nxt      = 8'd0;
                end else begin
                    w_state_nxt     = S_IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset clears outputs without a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_last      <= c_LAST_RST;
            r_hold      <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_last      <= w_last_nxt;
            r_hold      <= w_hold_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one resource among an array of NUM_REQ identical requester instances.
- Issues a registered one-hot grant plus a binary grant index, so array-instance consumers can select their slice directly.
- Enforces a maximum hold time with forced preemption, and inserts one idle cycle between successive owners.
- Sits between the requester instance array and the shared datapath select logic.

Parameters:
- NUM_REQ, 3: number of requesters; legal range 1..16.
- ID_W, 2: width of gnt_id; must satisfy 2**ID_W >= NUM_REQ.
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant; legal range 1..255.

Ports:
- clock  input  1: sole clock; all state updates on rising edge.
- reset_n  input  1: asynchronous, active-low reset.
- req  input  NUM_REQ: per-requester request level; bit i belongs to requester i.
- done  input  NUM_REQ: per-requester release pulse; only the current owner's bit is honoured.
- gnt  output  NUM_REQ: registered one-hot grant; all-zero when no owner.
- gnt_valid  output  1: registered; equals OR of gnt.
- gnt_id  output  ID_W: registered index of the owner; holds its last value when gnt_valid=0.
- timeout  output  1: registered one-cycle pulse flagging that the previous grant ended by forced preemption.

Behaviour:
- Reset (async assert, any time, including mid-grant):
  - gnt=0, gnt_valid=0, gnt_id=0, timeout=0, hold counter=0, state=IDLE.
  - Priority pointer last=NUM_REQ-1, so requester 0 wins the first arbitration.
  - Outputs clear immediately, with no clock edge required.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0 at an edge, select the first set bit searching cyclically from last+1 upward.
  - Load gnt (one-hot), gnt_id and gnt_valid=1; hold counter=0; go to GRANT.
  - Latency from req sampled to gnt visible: 1 cycle.
  - If req==0, stay in IDLE.
- GRANT (owner o):
  - Each edge, evaluate in priority order:
    1. done[o]=1 or req[o]=0: normal release. Go to GAP, timeout=0.
    2. Hold counter == MAX_HOLD-1: forced release. Go to GAP, timeout=1.
    3. Otherwise stay in GRANT; hold counter +1.
  - A release that coincides with expiry counts as normal: no timeout.
  - On any release: gnt=0, gnt_valid=0, last=o; gnt_id keeps o.
  - The grant is therefore high for at most exactly MAX_HOLD cycles.
  - done bits of non-owners are ignored; req changes of non-owners do not disturb the owner.
- GAP:
  - Exactly one cycle with gnt=0.
  - timeout is high only in this cycle, and only after a forced release.
  - At the GAP exit edge, arbitrate exactly as in IDLE, using the updated last.
  - If any req is set, go to GRANT; otherwise go to IDLE. timeout returns to 0.
- Fairness and ordering:
  - The pointer rotates only on release, so with all requesters active the grant order is strictly cyclic.
  - A preempted owner that keeps requesting is re-granted only after every other active requester has been served.
  - If it is the sole requester, it is re-granted straight after the GAP.
- Invariants:
  - gnt is never multi-hot.
  - gnt_valid==|gnt at every cycle.
  - Minimum spacing between two grants is one GAP cycle, even for the same requester.
- NUM_REQ=1: the pointer is degenerate; behaviour is otherwise identical and gnt_id stays 0.
- Hold counter width is 8 bits; it is never compared beyond MAX_HOLD-1, so no wrap is possible.

Test Plan (NUM_REQ=3, ID_W=2, MAX_HOLD=4):
- Reset idle: release reset_n with req=3'b000 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- Basic grant and handoff: req=3'b101 at edge 0 -> gnt=3'b001, gnt_id=0 after edge 0. Pulse done=3'b001 at edge 2 -> gnt=0 for one cycle, then gnt=3'b100, gnt_id=2.
- Rotation: req=3'b111 held, with done pulsed by each owner on its 2nd grant cycle -> grant sequence 001,010,100,001, each separated by one gnt=0 cycle, timeout never set.
- Preemption: req=3'b010 held, done=0 -> gnt=3'b010 for exactly 4 cycles, then one gap cycle with timeout=1, then gnt=3'b010 again. Raising done[1] on the 4th cycle instead -> gap with timeout=0.
- Withdraw and foreign done: owner 0 granted, done=3'b100 pulsed -> no effect; req[0] dropped -> gnt clears at the next edge, timeout=0.
- Async reset mid-grant: assert reset_n low between edges while gnt=3'b100 -> gnt=0 immediately. After release, req=3'b110 -> gnt=3'b010 first (pointer reset).
